// File: rtl/chiplet_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chiplet_types_pkg
// Description : Shared flit, node-id and route-LUT types plus the flit field
//               positions used by the switch route computation.
// Revision    : 1.0 - initial release
// ============================================================================
package chiplet_types_pkg;

    typedef logic [4:0] node_id_t;

    typedef struct packed {
        logic [31:0] payload;
    } flit_t;

    // Format code carried by in-band switch configuration packets.
    localparam logic [3:0] FMT_SWITCH_CFG = 4'hA;

    // Field positions inside flit_t.payload.
    localparam int FMT_MSB      = 31;
    localparam int FMT_LSB      = 28;
    localparam int DEST_MSB     = 27;
    localparam int DEST_LSB     = 23;
    localparam int CFG_HI_MSB   = 22;
    localparam int CFG_HI_LSB   = 15;
    localparam int CFG_ADDR_MSB = 14;
    localparam int CFG_ADDR_LSB = 7;
    localparam int CFG_LO_MSB   = 6;
    localparam int CFG_LO_LSB   = 0;

    // Widest out_sel a LUT entry can hold; instances use the low OSW bits.
    localparam int OSW_MAX = 8;

    typedef struct packed {
        logic               valid;
        logic [OSW_MAX-1:0] out_sel;
    } route_lut_entry_t;

    // Configuration data is split around the address field in the flit.
    function automatic logic [14:0] cfg_data(input flit_t f);
        return {f.payload[CFG_HI_MSB:CFG_HI_LSB], f.payload[CFG_LO_MSB:CFG_LO_LSB]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Picks the first asserted
//               request at or after ptr, wrapping around.
// Ports       : req       - request vector
//               ptr       - highest-priority index this cycle
//               any       - at least one request granted
//               grant_oh  - one-hot grant
//               grant_idx - binary index of the grant
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx
);

    always_comb begin
        int j;
        j         = 0;
        any       = 1'b0;
        grant_oh  = '0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[j]) begin
                any         = 1'b1;
                grant_oh[j] = 1'b1;
                grant_idx   = IW'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/route_compute_rr.sv
`default_nettype none
// ============================================================================
// Module      : route_compute_rr
// Description : Serialized route computation. Round-robin picks one unrouted
//               head flit, then either writes the route LUT (config packet
//               for this node, head popped) or looks the destination up and
//               offers the result on a valid/ready channel.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               head_valid    - buffer k holds an unrouted head flit
//               in_flit       - head flit per buffer
//               pkt_done      - buffer k's packet has drained; re-arms k
//               head_pop      - one-cycle consume pulse (config packets)
//               route_valid   - result pending
//               route_ready   - allocator accepts result
//               route_buf     - buffer owning the result
//               route_out_sel - selected output port
//               route_miss    - no valid LUT entry for the destination
// Revision    : 1.0 - initial release
// ============================================================================
module route_compute_rr
    import chiplet_types_pkg::*;
#(
    parameter  node_id_t NODE         = node_id_t'(1),
    parameter  int       NUM_BUFFERS  = 4,
    parameter  int       NUM_OUTPORTS = 4,
    parameter  int       LUT_DEPTH    = 32,
    localparam int       BW           = $clog2(NUM_BUFFERS),
    localparam int       OSW          = $clog2(NUM_OUTPORTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUFFERS-1:0] head_valid,
    input  flit_t                  in_flit [NUM_BUFFERS],
    input  logic [NUM_BUFFERS-1:0] pkt_done,
    output logic [NUM_BUFFERS-1:0] head_pop,
    output logic                   route_valid,
    input  logic                   route_ready,
    output logic [BW-1:0]          route_buf,
    output logic [OSW-1:0]         route_out_sel,
    output logic                   route_miss
);

    localparam int         LIW         = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
    localparam logic [8:0] LUT_DEPTH_W = 9'(LUT_DEPTH);
    localparam logic [8:0] OUTPORTS_W  = 9'(NUM_OUTPORTS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]             r_state;
    logic [BW-1:0]          r_rr;
    logic [NUM_BUFFERS-1:0] r_routed;
    logic [BW-1:0]          r_g;
    logic [NUM_BUFFERS-1:0] r_g_oh;
    logic [3:0]             r_fmt;
    node_id_t               r_dest;
    logic [7:0]             r_addr;
    route_lut_entry_t       r_cfg_entry;
    route_lut_entry_t       r_lut [LUT_DEPTH];
    logic [BW-1:0]          r_buf;
    logic [OSW-1:0]         r_out_sel;
    logic                   r_miss;

    logic [NUM_BUFFERS-1:0] w_eligible;
    logic                   w_any;
    logic [NUM_BUFFERS-1:0] w_grant_oh;
    logic [BW-1:0]          w_grant_idx;
    flit_t                  w_sel_flit;
    logic [14:0]            w_cfg_data;
    logic                   w_is_cfg_node;
    logic                   w_addr_ok;
    logic                   w_dest_ok;
    logic [LIW-1:0]         w_addr_idx;
    logic [LIW-1:0]         w_dest_idx;
    route_lut_entry_t       w_lut_rd;
    logic                   w_lut_miss;
    logic [NUM_BUFFERS-1:0] w_routed_set;

    assign w_eligible = head_valid & ~r_routed;

    rr_arbiter #(
        .N (NUM_BUFFERS)
    ) u_arb (
        .req       (w_eligible),
        .ptr       (r_rr),
        .any       (w_any),
        .grant_oh  (w_grant_oh),
        .grant_idx (w_grant_idx)
    );

    always_comb begin
        w_sel_flit = '0;
        for (int k = 0; k < NUM_BUFFERS; k++) begin
            if (w_grant_oh[k]) begin
                w_sel_flit = in_flit[k];
            end
        end
    end

    assign w_cfg_data    = cfg_data(w_sel_flit);
    assign w_is_cfg_node = (r_fmt == FMT_SWITCH_CFG) && (r_dest == NODE);
    assign w_addr_ok     = {1'b0, r_addr} < LUT_DEPTH_W;
    assign w_dest_ok     = {4'b0, r_dest} < LUT_DEPTH_W;
    assign w_addr_idx    = r_addr[LIW-1:0];

    generate
        if (LIW <= 5) begin : g_dest_idx_narrow
            assign w_dest_idx = r_dest[LIW-1:0];
        end else begin : g_dest_idx_wide
            assign w_dest_idx = {{(LIW-5){1'b0}}, r_dest};
        end
    endgenerate

    // An entry selecting a port beyond NUM_OUTPORTS is treated as a miss.
    assign w_lut_rd   = r_lut[w_dest_idx];
    assign w_lut_miss = !w_lut_rd.valid || ({1'b0, w_lut_rd.out_sel} >= OUTPORTS_W);

    assign w_routed_set = ((r_state == S_RESP) && route_ready) ? r_g_oh : '0;

    assign head_pop      = ((r_state == S_LOOKUP) && w_is_cfg_node) ? r_g_oh : '0;
    assign route_valid   = (r_state == S_RESP);
    assign route_buf     = r_buf;
    assign route_out_sel = r_out_sel;
    assign route_miss    = r_miss;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_routed    <= '0;
            r_g         <= '0;
            r_g_oh      <= '0;
            r_fmt       <= '0;
            r_dest      <= '0;
            r_addr      <= '0;
            r_cfg_entry <= '0;
            r_buf       <= '0;
            r_out_sel   <= '0;
            r_miss      <= 1'b0;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_lut[i] <= '0;
            end
        end else begin
            // A drained packet re-arms its buffer even if it is being marked
            // routed in the same cycle.
            r_routed <= (r_routed | w_routed_set) & ~pkt_done;

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_g                 <= w_grant_idx;
                        r_g_oh              <= w_grant_oh;
                        r_fmt               <= w_sel_flit.payload[FMT_MSB:FMT_LSB];
                        r_dest              <= w_sel_flit.payload[DEST_MSB:DEST_LSB];
                        r_addr              <= w_sel_flit.payload[CFG_ADDR_MSB:CFG_ADDR_LSB];
                        r_cfg_entry.valid   <= w_cfg_data[OSW];
                        r_cfg_entry.out_sel <= OSW_MAX'(w_cfg_data[OSW-1:0]);
                        r_rr                <= (w_grant_idx == BW'(NUM_BUFFERS - 1)) ?
                                               '0 : w_grant_idx + 1'b1;
                        r_state             <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_is_cfg_node) begin
                        // Out-of-range addresses are dropped; the head is
                        // still consumed via head_pop.
                        if (w_addr_ok) begin
                            r_lut[w_addr_idx] <= r_cfg_entry;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_buf <= r_g;
                        if (r_dest == NODE) begin
                            r_out_sel <= '0;
                            r_miss    <= 1'b0;
                        end else if (!w_dest_ok || w_lut_miss) begin
                            r_out_sel <= '0;
                            r_miss    <= 1'b1;
                        end else begin
                            r_out_sel <= w_lut_rd.out_sel[OSW-1:0];
                            r_miss    <= 1'b0;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (route_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_route_compute_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_route_compute_rr
// Description : Directed bench for route_compute_rr. Stimulus pushes expected
//               route results and head_pop pulses into queues; a monitor
//               compares them whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_route_compute_rr;
    import chiplet_types_pkg::*;

    typedef struct packed {
        logic [1:0] b;
        logic [1:0] sel;
        logic       miss;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] head_valid;
    flit_t      in_flit [4];
    logic [3:0] pkt_done;
    logic [3:0] head_pop;
    logic       route_valid;
    logic       route_ready;
    logic [1:0] route_buf;
    logic [1:0] route_out_sel;
    logic       route_miss;

    exp_t       exp_q [$];
    logic [3:0] pop_q [$];
    int         checks   = 0;
    int         failures = 0;
    int         n_acc    = 0;
    int         n_pop    = 0;

    route_compute_rr #(
        .NODE         (node_id_t'(1)),
        .NUM_BUFFERS  (4),
        .NUM_OUTPORTS (4),
        .LUT_DEPTH    (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .head_valid    (head_valid),
        .in_flit       (in_flit),
        .pkt_done      (pkt_done),
        .head_pop      (head_pop),
        .route_valid   (route_valid),
        .route_ready   (route_ready),
        .route_buf     (route_buf),
        .route_out_sel (route_out_sel),
        .route_miss    (route_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flit_t mk_data(input logic [4:0] d);
        return flit_t'({4'h0, d, 23'h0});
    endfunction

    function automatic flit_t mk_cfg(input logic [4:0] d, input logic [7:0] a,
                                     input logic v, input logic [1:0] s);
        return flit_t'({FMT_SWITCH_CFG, d, 8'h00, a, 4'h0, v, s});
    endfunction

    function automatic exp_t mk_exp(input int b, input int sel, input int miss);
        exp_t e;
        e.b    = 2'(b);
        e.sel  = 2'(sel);
        e.miss = 1'(miss);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input int k);
        head_valid[k] = 1'b0;
        pkt_done[k]   = 1'b1;
        tick();
        pkt_done[k]   = 1'b0;
    endtask

    task automatic wait_acc(input int target, input string nm);
        int i;
        i = 0;
        do begin
            @(posedge clk);
            i++;
        end while (n_acc < target && i < 60);
        #1;
        checks++;
        if (n_acc < target) begin
            failures++;
            $display("FAIL %s accepted=%0d required=%0d (timeout)", nm, n_acc, target);
        end
    endtask

    task automatic wait_pop(input int target, input string nm);
        int i;
        i = 0;
        do begin
            @(posedge clk);
            i++;
        end while (n_pop < target && i < 60);
        #1;
        checks++;
        if (n_pop < target) begin
            failures++;
            $display("FAIL %s pops=%0d required=%0d (timeout)", nm, n_pop, target);
        end
    endtask

    task automatic wait_valid(input string nm);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!route_valid && i < 20);
        checks++;
        if (!route_valid) begin
            failures++;
            $display("FAIL %s route_valid=0 required=1 (timeout)", nm);
        end
    endtask

    // Monitor: every cycle a result is presented it must equal the queue head
    // (this also catches outputs changing while stalled); pop on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (route_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_route buf=%0d sel=%0d miss=%0d required=none",
                             route_buf, route_out_sel, route_miss);
                end else begin
                    if ({route_buf, route_out_sel, route_miss} !== exp_q[0]) begin
                        failures++;
                        $display("FAIL route buf/sel/miss actual=%0d/%0d/%0d required=%0d/%0d/%0d",
                                 route_buf, route_out_sel, route_miss,
                                 exp_q[0].b, exp_q[0].sel, exp_q[0].miss);
                    end
                    if (route_ready) begin
                        void'(exp_q.pop_front());
                        n_acc++;
                    end
                end
            end
            if (head_pop != 4'b0000) begin
                checks++;
                if (pop_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pop actual=%b required=none", head_pop);
                end else begin
                    if (head_pop !== pop_q[0]) begin
                        failures++;
                        $display("FAIL head_pop actual=%b required=%b", head_pop, pop_q[0]);
                    end
                    void'(pop_q.pop_front());
                    n_pop++;
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        head_valid  = '0;
        pkt_done    = '0;
        route_ready = 1'b1;
        for (int k = 0; k < 4; k++) in_flit[k] = '0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_route_valid", route_valid, 0);
        chk("rst_route_buf", route_buf, 0);
        chk("rst_route_out_sel", route_out_sel, 0);
        chk("rst_route_miss", route_miss, 0);
        chk("rst_head_pop", head_pop, 0);
        tick();
        rst = 1'b0;
        tick();

        // Empty LUT: dest 5 misses; valid exactly two cycles after eligibility
        exp_q.push_back(mk_exp(0, 0, 1));
        in_flit[0] = mk_data(5'd5);
        head_valid[0] = 1'b1;
        @(negedge clk); chk("lat_c0_valid", route_valid, 0);
        @(negedge clk); chk("lat_c1_valid", route_valid, 0);
        @(negedge clk); chk("lat_c2_valid", route_valid, 1);
        wait_acc(1, "first_miss");
        retire(0);

        // Cfg to this node: LUT[5] = {valid, 2}, head popped, no route
        pop_q.push_back(4'b0010);
        in_flit[1] = mk_cfg(5'd1, 8'd5, 1'b1, 2'd2);
        head_valid[1] = 1'b1;
        wait_pop(1, "cfg_pop");
        head_valid[1] = 1'b0;
        exp_q.push_back(mk_exp(1, 2, 0));
        in_flit[1] = mk_data(5'd5);
        head_valid[1] = 1'b1;
        wait_acc(2, "lut_hit");
        retire(1);

        // Cfg with address >= LUT_DEPTH (40 aliases 8) is popped but ignored
        pop_q.push_back(4'b0100);
        in_flit[2] = mk_cfg(5'd1, 8'd40, 1'b1, 2'd3);
        head_valid[2] = 1'b1;
        wait_pop(2, "cfg_oob_pop");
        head_valid[2] = 1'b0;
        exp_q.push_back(mk_exp(2, 0, 1));
        in_flit[2] = mk_data(5'd8);
        head_valid[2] = 1'b1;
        wait_acc(3, "oob_ignored");
        retire(2);

        // Cfg to another node is routed as data (LUT[9] empty) and writes nothing
        exp_q.push_back(mk_exp(3, 0, 1));
        in_flit[3] = mk_cfg(5'd9, 8'd5, 1'b1, 2'd1);
        head_valid[3] = 1'b1;
        wait_acc(4, "foreign_cfg");
        retire(3);

        // dest == NODE -> port 0; stall 5 cycles, outputs stable, one grant
        route_ready = 1'b0;
        exp_q.push_back(mk_exp(3, 0, 0));
        in_flit[3] = mk_data(5'd1);
        head_valid[3] = 1'b1;
        wait_valid("local_valid");
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", route_valid, 1);
        end
        @(posedge clk); #1;
        route_ready = 1'b1;
        wait_acc(5, "local_accept");
        repeat (4) tick();
        retire(3);

        // rr = 0: buffers 0 and 2 together -> 0 first. Buffer 0 re-armed during
        // its own RESP still waits behind buffer 2.
        exp_q.push_back(mk_exp(0, 2, 0));
        exp_q.push_back(mk_exp(2, 0, 1));
        exp_q.push_back(mk_exp(0, 0, 0));
        in_flit[0] = mk_data(5'd5);
        in_flit[2] = mk_data(5'd7);
        head_valid[0] = 1'b1;
        head_valid[2] = 1'b1;
        tick();
        tick();
        pkt_done[0] = 1'b1;
        in_flit[0] = mk_data(5'd1);
        tick();
        pkt_done[0] = 1'b0;
        wait_acc(8, "rr_order");
        head_valid = '0;
        pkt_done = 4'b0101;
        tick();
        pkt_done = '0;

        // pkt_done in the next grant cycle re-arms buffer 1 -> routed again
        exp_q.push_back(mk_exp(1, 0, 0));
        exp_q.push_back(mk_exp(1, 0, 0));
        in_flit[1] = mk_data(5'd1);
        head_valid[1] = 1'b1;
        wait_acc(9, "rearm_first");
        pkt_done[1] = 1'b1;
        tick();
        pkt_done[1] = 1'b0;
        wait_acc(10, "rearm_second");
        retire(1);

        // Reset during RESP drops the result and invalidates the LUT
        route_ready = 1'b0;
        exp_q.push_back(mk_exp(0, 2, 0));
        in_flit[0] = mk_data(5'd5);
        head_valid[0] = 1'b1;
        wait_valid("pre_rst_valid");
        @(posedge clk); #1;
        rst = 1'b1;
        head_valid = '0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", route_valid, 0);
        chk("rst_resp_miss", route_miss, 0);
        chk("rst_resp_out_sel", route_out_sel, 0);
        tick();
        rst = 1'b0;
        route_ready = 1'b1;
        exp_q.push_back(mk_exp(0, 0, 1));
        in_flit[0] = mk_data(5'd5);
        head_valid[0] = 1'b1;
        wait_acc(11, "lut_cleared");
        retire(0);
        repeat (4) tick();

        chk("exp_q_drained", exp_q.size(), 0);
        chk("pop_q_drained", pop_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
